// File: rtl/motion_de_axi_lite_regs.sv
// AXI4-Lite slave register file for the MotionDeIP S00_AXI control port.
// Define MOTION_DE_AXI_SLVERR_EN to answer out-of-range accesses with SLVERR.
//
// state        | meaning
// W_IDLE       | waiting for AW and/or W
// W_ADDR_HELD  | address latched, waiting for W
// W_DATA_HELD  | data and strobes latched, waiting for AW
// W_RESP       | write committed, BVALID held until BREADY
// R_IDLE       | waiting for AR
// R_VALID      | RDATA held, RVALID held until RREADY
module motion_de_axi_lite_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_VALID} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, wr_addr;
  logic [DW-1:0] wdata_q, wr_data, rd_word;
  logic [SW-1:0] wstrb_q, wr_strb;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [1:0] wr_resp, rd_resp;
  logic [DW-1:0] regs [NUM_REGS];
  logic unused_bits;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;

  assign wr_idx = wr_addr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

`ifdef MOTION_DE_AXI_SLVERR_EN
  assign wr_resp = ({1'b0, wr_idx} < (IDX_W+1)'(NUM_REGS)) ? 2'b00 : 2'b10;
  assign rd_resp = ({1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS)) ? 2'b00 : 2'b10;
`else
  assign wr_resp = 2'b00;
  assign rd_resp = 2'b00;
`endif

  // A channel that handshakes this cycle supplies its value directly;
  // otherwise the copy latched by an earlier handshake is used.
  always_comb begin
    w_next    = w_state;
    wr_commit = 1'b0;
    wr_addr   = aw_hs ? S_AXI_AWADDR : awaddr_q;
    wr_data   = w_hs ? S_AXI_WDATA : wdata_q;
    wr_strb   = w_hs ? S_AXI_WSTRB : wstrb_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_next    = W_RESP;
          wr_commit = 1'b1;
        end else if (aw_hs) begin
          w_next = W_ADDR_HELD;
        end else if (w_hs) begin
          w_next = W_DATA_HELD;
        end
      end
      W_ADDR_HELD: begin
        if (w_hs) begin
          w_next    = W_RESP;
          wr_commit = 1'b1;
        end
      end
      W_DATA_HELD: begin
        if (aw_hs) begin
          w_next    = W_RESP;
          wr_commit = 1'b1;
        end
      end
      W_RESP: begin
        if (b_hs) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they stay low
  // through reset and rise on the first edge after release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      reg_wr_pulse  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      w_state       <= w_next;
      S_AXI_AWREADY <= (w_next == W_IDLE) || (w_next == W_DATA_HELD);
      S_AXI_WREADY  <= (w_next == W_IDLE) || (w_next == W_ADDR_HELD);
      S_AXI_BVALID  <= (w_next == W_RESP);
      if (aw_hs) awaddr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_commit) S_AXI_BRESP <= wr_resp;
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_wr_pulse[i] <= wr_commit && (wr_idx == IDX_W'(i));
        if (wr_commit && (wr_idx == IDX_W'(i))) begin
          for (int k = 0; k < SW; k++) begin
            if (wr_strb[k]) regs[i][8*k +: 8] <= wr_data[8*k +: 8];
          end
        end
      end
    end
  end

  // Indices with no backing register read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_word = regs[i];
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_VALID;
      R_VALID: if (r_hs) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
    end else begin
      r_state       <= r_next;
      S_AXI_ARREADY <= (r_next == R_IDLE);
      S_AXI_RVALID  <= (r_next == R_VALID);
      if (ar_hs) begin
        S_AXI_RDATA <= rd_word;
        S_AXI_RRESP <= rd_resp;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[DW*g +: DW] = regs[g];
  end

endmodule

// File: tb/tb_motion_de_axi_lite_regs.sv
// Directed bench for motion_de_axi_lite_regs: a 4-register and a 3-register
// instance share all inputs; expected responses flow through scoreboard queues.
module tb_motion_de_axi_lite_regs;

`ifdef MOTION_DE_AXI_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic        aresetn;
  logic [3:0]  aw_addr, ar_addr;
  logic [2:0]  aw_prot, ar_prot;
  logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [1:0] b_resp, r_resp;
  logic [31:0] r_data;
  logic [127:0] reg_out;
  logic [3:0] pulse;

  logic aw_ready3, w_ready3, b_valid3, ar_ready3, r_valid3;
  logic [1:0] b_resp3, r_resp3;
  logic [31:0] r_data3;
  logic [95:0] reg_out3;
  logic [2:0] pulse3;

  motion_de_axi_lite_regs #(.NUM_REGS(4)) dut (
    .ACLK(tb_ACLK), .ARESETN(aresetn),
    .S_AXI_AWADDR(aw_addr), .S_AXI_AWPROT(aw_prot), .S_AXI_AWVALID(aw_valid), .S_AXI_AWREADY(aw_ready),
    .S_AXI_WDATA(w_data), .S_AXI_WSTRB(w_strb), .S_AXI_WVALID(w_valid), .S_AXI_WREADY(w_ready),
    .S_AXI_BRESP(b_resp), .S_AXI_BVALID(b_valid), .S_AXI_BREADY(b_ready),
    .S_AXI_ARADDR(ar_addr), .S_AXI_ARPROT(ar_prot), .S_AXI_ARVALID(ar_valid), .S_AXI_ARREADY(ar_ready),
    .S_AXI_RDATA(r_data), .S_AXI_RRESP(r_resp), .S_AXI_RVALID(r_valid), .S_AXI_RREADY(r_ready),
    .reg_out(reg_out), .reg_wr_pulse(pulse)
  );

  motion_de_axi_lite_regs #(.NUM_REGS(3)) dut3 (
    .ACLK(tb_ACLK), .ARESETN(aresetn),
    .S_AXI_AWADDR(aw_addr), .S_AXI_AWPROT(aw_prot), .S_AXI_AWVALID(aw_valid), .S_AXI_AWREADY(aw_ready3),
    .S_AXI_WDATA(w_data), .S_AXI_WSTRB(w_strb), .S_AXI_WVALID(w_valid), .S_AXI_WREADY(w_ready3),
    .S_AXI_BRESP(b_resp3), .S_AXI_BVALID(b_valid3), .S_AXI_BREADY(b_ready),
    .S_AXI_ARADDR(ar_addr), .S_AXI_ARPROT(ar_prot), .S_AXI_ARVALID(ar_valid), .S_AXI_ARREADY(ar_ready3),
    .S_AXI_RDATA(r_data3), .S_AXI_RRESP(r_resp3), .S_AXI_RVALID(r_valid3), .S_AXI_RREADY(r_ready),
    .reg_out(reg_out3), .reg_wr_pulse(pulse3)
  );

  typedef struct {
    logic [1:0] resp3;
    logic [3:0] pulse;
    logic [2:0] pulse3;
  } b_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] data3;
    logic [1:0]  resp3;
  } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  logic [31:0] model [4];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_hold);
    b_exp_t e;
    logic [31:0] m;
    int idx;
    bit aw_done, w_done, aw_now, w_now;
    idx      = int'(a[3:2]);
    e.pulse  = 4'(1 << idx);
    e.pulse3 = (idx < 3) ? 3'(1 << idx) : 3'b000;
    e.resp3  = (idx < 3) ? 2'b00 : OOR_RESP;
    bq.push_back(e);
    m = model[idx];
    for (int k = 0; k < 4; k++) if (s[k]) m[8*k +: 8] = d[8*k +: 8];
    model[idx] = m;
    aw_done = 0;
    w_done  = 0;
    b_ready = 1'b0;
    for (int n = 0; n < 40 && !(aw_done && w_done); n++) begin
      if (!aw_done && n == aw_dly) begin aw_addr = a; aw_valid = 1'b1; end
      if (!w_done && n == w_dly) begin w_data = d; w_strb = s; w_valid = 1'b1; end
      aw_now = aw_valid && aw_ready;
      w_now  = w_valid && w_ready;
      @(posedge tb_ACLK); #1;
      if (aw_now) begin aw_done = 1; aw_valid = 1'b0; end
      if (w_now) begin w_done = 1; w_valid = 1'b0; end
      if (!(aw_done && w_done)) chk("bvalid_early", b_valid, 1'b0);
    end
    chk("wr_handshake", {aw_done, w_done}, 2'b11);
    if (!(aw_done && w_done)) return;
    chk("bvalid_latency", {b_valid3, b_valid}, 2'b11);
    e = bq.pop_front();
    chk("bresp", b_resp, 2'b00);
    chk("bresp3", b_resp3, e.resp3);
    chk("wr_pulse", pulse, e.pulse);
    chk("wr_pulse3", pulse3, e.pulse3);
    for (int n = 0; n < b_hold; n++) begin
      @(posedge tb_ACLK); #1;
      chk("b_hold_valid", b_valid, 1'b1);
      chk("b_hold_resp3", b_resp3, e.resp3);
      chk("b_hold_wready", {aw_ready, w_ready}, 2'b00);
      chk("wr_pulse_once", {pulse3, pulse}, 7'd0);
    end
    b_ready = 1'b1;
    @(posedge tb_ACLK); #1;
    b_ready = 1'b0;
    chk("bvalid_clear", {b_valid3, b_valid}, 2'b00);
    chk("wr_pulse_clear", {pulse3, pulse}, 7'd0);
    chk("wready_back", {aw_ready, w_ready}, 2'b11);
  endtask

  task automatic do_read(input logic [3:0] a, input int r_hold);
    r_exp_t e;
    int idx;
    bit done, now;
    idx     = int'(a[3:2]);
    e.data  = model[idx];
    e.data3 = (idx < 3) ? model[idx] : 32'd0;
    e.resp3 = (idx < 3) ? 2'b00 : OOR_RESP;
    rq.push_back(e);
    ar_addr  = a;
    ar_valid = 1'b1;
    r_ready  = 1'b0;
    done     = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      now = ar_ready;
      @(posedge tb_ACLK); #1;
      if (now) begin done = 1; ar_valid = 1'b0; end
    end
    chk("rd_handshake", done, 1'b1);
    if (!done) return;
    chk("rvalid_latency", {r_valid3, r_valid}, 2'b11);
    e = rq.pop_front();
    chk("rdata", r_data, e.data);
    chk("rresp", r_resp, 2'b00);
    chk("rdata3", r_data3, e.data3);
    chk("rresp3", r_resp3, e.resp3);
    for (int n = 0; n < r_hold; n++) begin
      @(posedge tb_ACLK); #1;
      chk("r_hold_valid", r_valid, 1'b1);
      chk("r_hold_data", r_data, e.data);
      chk("r_hold_arready", ar_ready, 1'b0);
    end
    r_ready = 1'b1;
    @(posedge tb_ACLK); #1;
    r_ready = 1'b0;
    chk("rvalid_clear", {r_valid3, r_valid}, 2'b00);
    chk("arready_back", ar_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    aresetn = 1'b1;
    aw_addr = '0; ar_addr = '0; aw_prot = '0; ar_prot = '0;
    aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
    w_data = '0; w_strb = '0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    #2 aresetn = 1'b0;
    #500;
    chk("rst_ready", {aw_ready, w_ready, ar_ready, aw_ready3, w_ready3, ar_ready3}, 6'd0);
    chk("rst_valid", {b_valid, r_valid, b_valid3, r_valid3}, 4'd0);
    chk("rst_resp", {b_resp, r_resp, b_resp3, r_resp3}, 8'd0);
    chk("rst_rdata", {r_data3, r_data}, 64'd0);
    chk("rst_reg_out", reg_out, 128'd0);
    chk("rst_reg_out3", reg_out3, 96'd0);
    chk("rst_pulse", {pulse3, pulse}, 7'd0);
    aresetn = 1'b1;
    #1;
    chk("ready_before_edge", {aw_ready, w_ready, ar_ready}, 3'b000);
    @(posedge tb_ACLK); #1;
    chk("ready_after_release", {aw_ready, w_ready, ar_ready}, 3'b111);

    do_write(4'h0, 32'h0101FFFF, 4'hF, 0, 0, 0);
    do_write(4'h4, 32'habcd0001, 4'hF, 0, 0, 0);
    do_write(4'h8, 32'hdead0011, 4'hF, 0, 0, 0);
    do_write(4'hC, 32'hbeef0011, 4'hF, 0, 0, 0);
    do_read(4'h0, 0);
    do_read(4'h4, 0);
    do_read(4'h8, 0);
    do_read(4'hC, 0);
    chk("reg_out", reg_out, {model[3], model[2], model[1], model[0]});
    chk("reg_out3", reg_out3, {model[2], model[1], model[0]});

    do_write(4'h4, 32'h12345678, 4'hF, 0, 3, 0);
    do_read(4'h4, 0);
    do_write(4'h4, 32'h12345678, 4'hF, 3, 0, 0);
    do_read(4'h4, 0);

    do_write(4'h8, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(4'h8, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    do_read(4'h8, 0);
    chk("strobe_model", model[2], 32'h11BB33DD);

    do_write(4'h0, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
    do_read(4'h0, 0);

    do_write(4'h4, 32'hCAFEF00D, 4'hF, 0, 0, 5);
    do_read(4'h4, 5);

    do_write(4'h7, 32'h0BADBEEF, 4'b1100, 1, 0, 0);
    do_read(4'h6, 0);
    do_write(4'hF, 32'h5A5A5A5A, 4'hF, 0, 2, 0);
    do_read(4'hD, 2);

    old      = model[0];
    aw_addr  = 4'h0; aw_valid = 1'b1;
    w_data   = 32'h5555AAAA; w_strb = 4'hF; w_valid = 1'b1;
    ar_addr  = 4'h0; ar_valid = 1'b1;
    @(posedge tb_ACLK); #1;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    chk("conflict_valids", {b_valid, r_valid}, 2'b11);
    chk("conflict_rdata", r_data, old);
    chk("conflict_pulse", pulse, 4'b0001);
    model[0] = 32'h5555AAAA;
    b_ready = 1'b1; r_ready = 1'b1;
    @(posedge tb_ACLK); #1;
    b_ready = 1'b0; r_ready = 1'b0;
    do_read(4'h0, 0);

    chk("final_reg_out", reg_out, {model[3], model[2], model[1], model[0]});
    chk("final_reg_out3", reg_out3, {model[2], model[1], model[0]});
    chk("queues_empty", bq.size() + rq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/motion_de_axi_lite_regs.md
Name: motion_de_axi_lite_regs

Overview:
- AXI4-Lite slave register file; the responder end of the MotionDeIP S00_AXI control interface.
- Accepts single-beat writes and reads from the system master and holds NUM_REGS 32-bit read/write registers.
- Register contents and per-register write pulses go to the motion-detection datapath.
- Sits between the AXI interconnect / BFM master and the MotionDeIP core.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; register index = addr[C_S_AXI_ADDR_WIDTH-1:2].
- NUM_REGS, 4, implemented registers, at most 2**(C_S_AXI_ADDR_WIDTH-2).

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
- reg_out  out  NUM_REGS*32  register contents; reg i at bits [32*i+31:32*i]
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe; bit i high in the cycle after reg i is written

Behaviour:
- Reset (ARESETN low, asynchronous): all registers 0, reg_out 0, reg_wr_pulse 0.
- Also during reset: AWREADY, WREADY, ARREADY, BVALID and RVALID all 0; BRESP and RRESP 2'b00; RDATA 0.
- Ready outputs go high on the first ACLK edge after reset release.
- Write FSM states and transitions:
  - W_IDLE: AWREADY=1, WREADY=1.
  - W_IDLE -> W_ADDR_HELD on AW handshake alone; address latched.
  - W_IDLE -> W_DATA_HELD on W handshake alone; data and strobes latched.
  - W_IDLE -> W_RESP on AW and W handshake in the same cycle.
  - W_ADDR_HELD: AWREADY=0, WREADY=1; -> W_RESP on W handshake.
  - W_DATA_HELD: AWREADY=1, WREADY=0; -> W_RESP on AW handshake.
  - W_RESP: both readies 0, BVALID=1, held until BREADY; -> W_IDLE on B handshake.
  - AW and W are accepted independently, in either order.
- Write commit (the edge entering W_RESP):
  - Byte k of the target register is updated only where WSTRB[k]=1.
  - reg_wr_pulse[idx] pulses for exactly one cycle, aligned with the first BVALID cycle.
  - Pulse asserts even when WSTRB=0.
- Write latency: BVALID rises 1 cycle after the later of the AW and W handshakes. Maximum write throughput is one write per 2 cycles.
- Read FSM states and transitions:
  - R_IDLE: ARREADY=1.
  - On AR handshake: RDATA registered from the addressed register; -> R_VALID.
  - R_VALID: ARREADY=0, RVALID=1; RDATA and RRESP held stable until RREADY; -> R_IDLE on R handshake.
- Read latency: RVALID rises 1 cycle after the AR handshake.
- Same-edge conflict: a read sampled on the same edge as a write commit to the same register returns the pre-write value.
- Address bits [1:0] are ignored; unaligned addresses map to the containing word.
- Out-of-range index (idx >= NUM_REGS): write is discarded with no reg_wr_pulse; read returns 0. Response code is per the Optional Feature.
- Reset asserted mid-transaction: any pending transaction is dropped with no response; the master must reissue it.

Optional Feature:
- Macro: MOTION_DE_AXI_SLVERR_EN.
- Defined: out-of-range read or write returns RESP=2'b10 (SLVERR); in-range accesses return 2'b00.
- Undefined: every access returns 2'b00 (OKAY).
- Data behaviour for out-of-range accesses is identical in both cases.

Test Plan:
- Reset: hold ARESETN low 500 ns -> all outputs 0; 1 cycle after release AWREADY=WREADY=ARREADY=1.
- Sequential write/read at 0x0, 0x4, 0x8, 0xC with 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 -> each BRESP=00, readback equal, reg_wr_pulse bits 0..3 pulse once each.
- AW issued 3 cycles before W for addr 0x4, data 0x12345678 -> BVALID exactly 1 cycle after the W handshake; repeat with W first -> same result.
- Write 0xAABBCCDD with WSTRB=4'b0101 over 0x11223344 at 0x8 -> readback 0x11BB33DD.
- BREADY and RREADY held low 5 cycles -> BVALID, RVALID, RDATA stable; AWREADY=WREADY=0 and ARREADY=0 meanwhile.
- Access with NUM_REGS=3 at 0xC -> RDATA 0, no pulse; RESP=10 with MOTION_DE_AXI_SLVERR_EN, 00 without.
